// File: rtl/vend_if.sv
// Vending controller handshake bundle: coin pulses, selects, dispense and change handshakes.
// Latency: none (wires only).
// Backpressure: dispense and change use req/ack; the controller holds a request until it is acked.
//   master: coin front end, buttons, dispenser and hopper (drive inputs, observe outputs)
//   slave : vend_ctrl
interface vend_if #(
  parameter int CREDIT_W = 4
);
  logic                coin_5;
  logic                coin_10;
  logic                sel_a;
  logic                sel_b;
  logic                cancel;
  logic                disp_ack;
  logic                chg_ack;
  logic                disp_req;
  logic                disp_sel;
  logic                chg_req;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output coin_5, coin_10, sel_a, sel_b, cancel, disp_ack, chg_ack,
    input  disp_req, disp_sel, chg_req, coin_reject, credit, busy
  );

  modport slave (
    input  coin_5, coin_10, sel_a, sel_b, cancel, disp_ack, chg_ack,
    output disp_req, disp_sel, chg_req, coin_reject, credit, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// Vending sequencer: credit accumulation, two-price selection, dispense handshake, change return.
// Latency: every output is registered, 1 cycle after the input that causes it.
// Backpressure: disp_req / chg_req are held until acked; coins arriving while busy are rejected.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : vend_if.slave (coins, selects, cancel, acks in; requests, reject, credit, busy out)
module vend_ctrl #(
  parameter int CREDIT_W   = 4,
  parameter int PRICE_A    = 3,
  parameter int PRICE_B    = 4,
  parameter int MAX_CREDIT = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic clk,
  input  logic rst_n,
  vend_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t              state;
  logic [CREDIT_W-1:0] credit_q;
  logic [CNT_W-1:0]    cnt;
  logic                disp_req_q;
  logic                disp_sel_q;
  logic                chg_req_q;
  logic                coin_reject_q;
  logic                busy_q;

  // One extra bit so the ceiling compare cannot wrap.
  logic [CREDIT_W:0]   sum5;
  logic [CREDIT_W:0]   sum10;
  logic                fit5;
  logic                fit10;
  logic                acc5;
  logic                acc10;
  logic                coin_rej;
  logic                any_coin;
  logic [CREDIT_W-1:0] coin_sum;
  logic                afford_a;
  logic                afford_b;

  assign sum5     = {1'b0, credit_q} + (CREDIT_W+1)'(1);
  assign sum10    = {1'b0, credit_q} + (CREDIT_W+1)'(2);
  assign fit5     = sum5  <= (CREDIT_W+1)'(MAX_CREDIT);
  assign fit10    = sum10 <= (CREDIT_W+1)'(MAX_CREDIT);
  // coin_10 wins a simultaneous insertion; coin_5 is then refused outright.
  assign acc10    = bus.coin_10 && fit10;
  assign acc5     = bus.coin_5 && !bus.coin_10 && fit5;
  // Both coins refused together still yields one pulse (a single OR).
  assign coin_rej = (bus.coin_10 && !fit10) || (bus.coin_5 && (bus.coin_10 || !fit5));
  assign any_coin = bus.coin_5 || bus.coin_10;
  assign coin_sum = acc10 ? sum10[CREDIT_W-1:0] : sum5[CREDIT_W-1:0];
  assign afford_a = credit_q >= CREDIT_W'(PRICE_A);
  assign afford_b = credit_q >= CREDIT_W'(PRICE_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      credit_q      <= '0;
      cnt           <= '0;
      disp_req_q    <= 1'b0;
      disp_sel_q    <= 1'b0;
      chg_req_q     <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      coin_reject_q <= 1'b0;
      case (state)
        IDLE: begin
          coin_reject_q <= coin_rej;
          if (acc5 || acc10) begin
            credit_q <= coin_sum;
            cnt      <= '0;
            state    <= CREDIT;
          end
        end

        CREDIT: begin
          if (bus.cancel) begin
            // Leaving CREDIT this cycle, so any coin goes straight back.
            coin_reject_q <= any_coin;
            chg_req_q     <= 1'b1;
            busy_q        <= 1'b1;
            cnt           <= '0;
            state         <= CHANGE;
          end else if (bus.sel_a && afford_a) begin
            // Select is judged on pre-coin credit; the coin is refused.
            coin_reject_q <= any_coin;
            credit_q      <= credit_q - CREDIT_W'(PRICE_A);
            disp_sel_q    <= 1'b0;
            disp_req_q    <= 1'b1;
            busy_q        <= 1'b1;
            cnt           <= '0;
            state         <= VEND;
          end else if (bus.sel_b && afford_b) begin
            coin_reject_q <= any_coin;
            credit_q      <= credit_q - CREDIT_W'(PRICE_B);
            disp_sel_q    <= 1'b1;
            disp_req_q    <= 1'b1;
            busy_q        <= 1'b1;
            cnt           <= '0;
            state         <= VEND;
          end else begin
            coin_reject_q <= coin_rej;
            if (acc5 || acc10) begin
              // An accepted coin restarts the inactivity window, even at TIMEOUT.
              credit_q <= coin_sum;
              cnt      <= '0;
            end else if (cnt == CNT_W'(TIMEOUT)) begin
              chg_req_q <= 1'b1;
              busy_q    <= 1'b1;
              cnt       <= '0;
              state     <= CHANGE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        VEND: begin
          coin_reject_q <= any_coin;
          if (bus.disp_ack) begin
            disp_req_q <= 1'b0;
            if (credit_q != '0) begin
              chg_req_q <= 1'b1;
              state     <= CHANGE;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end

        CHANGE: begin
          coin_reject_q <= any_coin;
          if (bus.chg_ack) begin
            credit_q <= credit_q - CREDIT_W'(1);
            if (credit_q == CREDIT_W'(1)) begin
              chg_req_q <= 1'b0;
              busy_q    <= 1'b0;
              state     <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.disp_req    = disp_req_q;
  assign bus.disp_sel    = disp_sel_q;
  assign bus.chg_req     = chg_req_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl (TIMEOUT=4). Stimulus pushes expected handshake/reject events
// into a queue; a negedge monitor pops and compares each event the DUT presents.
module tb_vend_ctrl;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int kind;  // 0 = coin reject, 1 = dispense handshake, 2 = change handshake
    int sel;
    int cred;
  } ev_t;

  ev_t exp_q[$];

  vend_if #(.CREDIT_W(4)) bus ();

  vend_ctrl #(
    .CREDIT_W(4), .PRICE_A(3), .PRICE_B(4), .MAX_CREDIT(8), .TIMEOUT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input int s, input int c);
    ev_t e;
    e.kind = k;
    e.sel  = s;
    e.cred = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input int k, input int s, input int c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d sel=%0d credit=%0d, expected none", k, s, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.sel != s || e.cred != c) begin
        errors++;
        $display("FAIL event: got kind=%0d sel=%0d credit=%0d, expected kind=%0d sel=%0d credit=%0d",
                 k, s, c, e.kind, e.sel, e.cred);
      end
    end
  endtask

  // Inputs change at posedge+1, so the negedge sees this cycle's values before the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.coin_reject)             got(0, 0, int'(bus.credit));
      if (bus.disp_req && bus.disp_ack) got(1, int'(bus.disp_sel), int'(bus.credit));
      if (bus.chg_req && bus.chg_ack)   got(2, 0, int'(bus.credit));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic c5, input logic c10);
    bus.coin_5  = c5;
    bus.coin_10 = c10;
    tick();
    bus.coin_5  = 1'b0;
    bus.coin_10 = 1'b0;
  endtask

  task automatic pulse_sel(input logic a, input logic b);
    bus.sel_a = a;
    bus.sel_b = b;
    tick();
    bus.sel_a = 1'b0;
    bus.sel_b = 1'b0;
  endtask

  task automatic ack_disp();
    bus.disp_ack = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
  endtask

  // Acks every other cycle; bounded so a stuck chg_req falls through to the final checks.
  task automatic drain(input string nm);
    for (int i = 0; i < 40 && bus.chg_req; i++) begin
      bus.chg_ack = (i % 2 == 0);
      tick();
    end
    bus.chg_ack = 1'b0;
    chk({nm, "_chg_req_low"}, bus.chg_req, 0);
    chk({nm, "_credit_zero"}, bus.credit, 0);
    chk({nm, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    bus.coin_5  = 1'b0;
    bus.coin_10 = 1'b0;
    bus.sel_a   = 1'b0;
    bus.sel_b   = 1'b0;
    bus.cancel  = 1'b0;
    bus.disp_ack = 1'b0;
    bus.chg_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.disp_req, bus.disp_sel, bus.chg_req, bus.coin_reject, bus.busy, bus.credit}, 0);
    rst_n = 1'b1;
    tick();

    // Stray acks with no request outstanding do nothing.
    bus.disp_ack = 1'b1;
    bus.chg_ack  = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
    bus.chg_ack  = 1'b0;
    chk("stray_ack", {bus.busy, bus.credit}, 0);

    // Exact purchase; ack lands in the first disp_req cycle.
    coin(1'b0, 1'b1);
    chk("exact_credit_2", bus.credit, 2);
    coin(1'b1, 1'b0);
    chk("exact_credit_3", bus.credit, 3);
    pulse_sel(1'b1, 1'b0);
    chk("exact_vend", {bus.disp_req, bus.disp_sel, bus.busy, bus.credit}, {3'b101, 4'd0});
    expect_ev(1, 0, 0);
    ack_disp();
    chk("exact_done", {bus.disp_req, bus.chg_req, bus.busy}, 0);

    // Change return with back-to-back acks.
    repeat (3) coin(1'b0, 1'b1);
    chk("chg_credit_6", bus.credit, 6);
    pulse_sel(1'b0, 1'b1);
    chk("chg_vend", {bus.disp_req, bus.disp_sel, bus.credit}, {2'b11, 4'd2});
    expect_ev(1, 1, 2);
    ack_disp();
    chk("chg_start", {bus.disp_req, bus.chg_req, bus.busy}, 3'b011);
    expect_ev(2, 0, 2);
    expect_ev(2, 0, 1);
    bus.chg_ack = 1'b1;
    tick();
    chk("chg_b2b_1", {bus.chg_req, bus.credit}, {1'b1, 4'd1});
    tick();
    bus.chg_ack = 1'b0;
    chk("chg_b2b_done", {bus.chg_req, bus.busy, bus.credit}, 0);

    // Simultaneous coins, ceiling, coin during VEND, held dispense.
    expect_ev(0, 0, 2);
    coin(1'b1, 1'b1);
    chk("both_coins", bus.credit, 2);
    repeat (3) coin(1'b0, 1'b1);
    chk("ceiling_8", bus.credit, 8);
    expect_ev(0, 0, 8);
    coin(1'b1, 1'b0);
    chk("over_ceiling", bus.credit, 8);
    pulse_sel(1'b1, 1'b0);
    chk("vend_from_8", {bus.disp_req, bus.disp_sel, bus.credit}, {2'b10, 4'd5});
    expect_ev(0, 0, 5);
    coin(1'b0, 1'b1);
    chk("coin_in_vend", {bus.disp_req, bus.credit}, {1'b1, 4'd5});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_disp", {bus.disp_req, bus.disp_sel, bus.credit}, {2'b10, 4'd5});
    end
    expect_ev(1, 0, 5);
    ack_disp();
    chk("held_to_change", {bus.disp_req, bus.chg_req}, 2'b01);
    for (int k = 5; k >= 1; k--) expect_ev(2, 0, k);
    drain("held");

    // Unaffordable select then cancel.
    coin(1'b0, 1'b1);
    pulse_sel(1'b0, 1'b1);
    chk("unaffordable", {bus.disp_req, bus.busy, bus.credit}, {2'b00, 4'd2});
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("cancel", {bus.chg_req, bus.busy, bus.credit}, {2'b11, 4'd2});
    expect_ev(2, 0, 2);
    expect_ev(2, 0, 1);
    drain("cancel");

    // Timeout with an unaffordable select held (must not restart the window).
    coin(1'b1, 1'b0);
    bus.sel_a = 1'b1;
    n = 0;
    while (!bus.chg_req && n < 20) begin
      tick();
      n++;
    end
    bus.sel_a = 1'b0;
    chk("timeout_cycles", n, 5);
    expect_ev(2, 0, 1);
    drain("timeout");

    // Reset mid-CHANGE.
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("pre_reset", {bus.chg_req, bus.credit}, {1'b1, 4'd3});
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", {bus.disp_req, bus.disp_sel, bus.chg_req, bus.coin_reject, bus.busy, bus.credit}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) tick();
    chk("after_reset", {bus.chg_req, bus.busy, bus.credit}, 0);

    repeat (2) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
